// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake bundle between the core and muldiv_unit
interface muldiv_if #(parameter int XLEN = 32);
  logic flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0] op;
  logic [XLEN-1:0] rs1, rs2, result;
  modport master (output flush, in_valid, op, rs1, rs2, out_ready, input in_ready, out_valid, result, busy);
  modport slave (input flush, in_valid, op, rs1, rs2, out_ready, output in_ready, out_valid, result, busy);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide beside the ALU, valid/ready handshake on both sides
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input logic clk,
  input logic rst,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(XLEN);
  state_t state, state_n;
  logic [2:0] op_q;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] m, hi, lo, hi_n, lo_n, res, res_n, sp_res, mag_a, mag_b;
  logic [XLEN:0] sum, t;
  logic [2*XLEN-1:0] prod_f, prod, prod_s;
  logic neg_q, neg_r, sa, sb, div0, ovf, accept, fast, last, ge;
  assign accept = bus.in_valid && state == IDLE && !bus.flush;
  assign sa = bus.rs1[XLEN-1] && (bus.op[2] ? !bus.op[0] : bus.op[1:0] != 2'b11);
  assign sb = bus.rs2[XLEN-1] && (bus.op[2] ? !bus.op[0] : !bus.op[1]);
  assign mag_a = sa ? -bus.rs1 : bus.rs1;
  assign mag_b = sb ? -bus.rs2 : bus.rs2;
  assign div0 = bus.op[2] && bus.rs2 == '0;
  assign ovf = bus.op[2] && !bus.op[0] && bus.rs1 == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2 == '1;
  assign sp_res = div0 ? (bus.op[1] ? bus.rs1 : '1) : (bus.op[1] ? '0 : bus.rs1);
  // m holds the multiplicand or divisor; {hi, lo} is the product / remainder:quotient pair
  assign fast = FAST_MUL && !op_q[2];
  assign last = fast || cnt == '0;
  assign sum = {1'b0, hi} + {1'b0, (lo[0] ? m : {XLEN{1'b0}})};
  assign t = {hi, lo[XLEN-1]};
  assign ge = t >= {1'b0, m};
  assign prod_f = {{XLEN{1'b0}}, m} * {{XLEN{1'b0}}, lo};
  assign {hi_n, lo_n} = fast ? prod_f
                      : op_q[2] ? {(ge ? t[XLEN-1:0] - m : t[XLEN-1:0]), lo[XLEN-2:0], ge}
                      : {sum, lo[XLEN-1:1]};
  assign prod = {hi_n, lo_n};
  assign prod_s = neg_q ? -prod : prod;
  assign res_n = op_q[2] ? (op_q[1] ? (neg_r ? -hi_n : hi_n) : (neg_q ? -lo_n : lo_n))
                         : (op_q[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
  always_comb begin
    state_n = state;
    if (bus.flush) state_n = IDLE;
    else if (accept) state_n = (div0 || ovf) ? DONE : CALC;
    else if (state == CALC && last) state_n = DONE;
    else if (state == DONE && bus.out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      {op_q, m, hi, lo, res, cnt, neg_q, neg_r} <= '0;
    end else if (accept) begin
      op_q <= bus.op;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      m <= bus.op[2] ? mag_b : mag_a;
      lo <= bus.op[2] ? mag_a : mag_b;
      hi <= '0;
      cnt <= CW'(XLEN - 1);
      if (div0 || ovf) res <= sp_res;
    end else if (state == CALC && !bus.flush) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= last ? cnt : cnt - 1'b1;
      if (last) res <= res_n;
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.result = res;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for an iterative (unit 0) and a FAST_MUL (unit 1) muldiv_unit
module tb_muldiv_unit;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
  logic clk = 1'b0, rst;
  logic [1:0] in_valid, flush, out_ready, in_ready, out_valid, busy;
  logic [1:0][2:0] op;
  logic [1:0][31:0] rs1, rs2, result;
  logic [31:0] exp_q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  muldiv_if #(.XLEN(32)) bus0 ();
  muldiv_if #(.XLEN(32)) bus1 ();
  muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  assign {bus0.in_valid, bus0.flush, bus0.out_ready, bus0.op, bus0.rs1, bus0.rs2} = {in_valid[0], flush[0], out_ready[0], op[0], rs1[0], rs2[0]};
  assign {bus1.in_valid, bus1.flush, bus1.out_ready, bus1.op, bus1.rs1, bus1.rs2} = {in_valid[1], flush[1], out_ready[1], op[1], rs1[1], rs2[1]};
  assign {in_ready[0], out_valid[0], busy[0], result[0]} = {bus0.in_ready, bus0.out_valid, bus0.busy, bus0.result};
  assign {in_ready[1], out_valid[1], busy[1], result[1]} = {bus1.in_ready, bus1.out_valid, bus1.busy, bus1.result};

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (o)
      MUL: begin p = 64'(sa * sb); return p[31:0]; end
      MULH: begin p = 64'(sa * sb); return p[63:32]; end
      MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      MULHU: begin p = 64'(ua * ub); return p[63:32]; end
      DIV: return b == 0 ? 32'hFFFFFFFF : 32'(sa / sb);
      DIVU: return b == 0 ? 32'hFFFFFFFF : 32'(ua / ub);
      REM: return b == 0 ? a : 32'(sa % sb);
      default: return b == 0 ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int lat_of(input int u, input logic [2:0] o, input logic [31:0] a, b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return (!o[2] && u == 1) ? 2 : 33;
  endfunction

  task automatic run(input int u, input logic [2:0] o, input logic [31:0] a, b, e, input int lat);
    int n;
    logic [31:0] want;
    n = 0;
    while (!in_ready[u] && n < 100) begin @(negedge clk); n++; end
    in_valid[u] = 1'b1; op[u] = o; rs1[u] = a; rs2[u] = b;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid[u] = 1'b0;
    n = 1;
    while (!out_valid[u] && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n != lat || out_valid[u] !== 1'b1) begin errors++; $display("FAIL latency u%0d op%0d: took %0d cycles, expected %0d", u, o, n, lat); end
    want = exp_q.pop_front();
    checks++;
    if (result[u] !== want) begin errors++; $display("FAIL result u%0d op%0d %h,%h: got %h expected %h", u, o, a, b, result[u], want); end
    @(negedge clk);
    checks++;
    if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0) begin errors++; $display("FAIL release u%0d: in_ready=%b out_valid=%b, expected 1 0", u, in_ready[u], out_valid[u]); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0 || busy[u] !== 1'b0 || result[u] !== 32'h0) begin
        errors++; $display("FAIL reset u%0d: in_ready=%b out_valid=%b busy=%b result=%h, expected 1 0 0 0", u, in_ready[u], out_valid[u], busy[u], result[u]);
      end
    end
  endtask

  task automatic test_div();
    run(0, DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run(0, REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run(0, REMU, 32'd7, 32'd2, 32'd1, 33);
    run(1, DIVU, 32'd1000, 32'd7, 32'd142, 33);
  endtask

  task automatic test_div_special();
    run(0, DIVU, 32'h1234, 32'h0, 32'hFFFFFFFF, 1);
    run(0, REM, 32'h1234, 32'h0, 32'h1234, 1);
    run(0, DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run(0, REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    run(1, DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33);
  endtask

  task automatic test_mul();
    for (int u = 0; u < 2; u++) begin
      run(u, MULH, 32'h80000000, 32'h80000000, 32'h40000000, u == 1 ? 2 : 33);
      run(u, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, u == 1 ? 2 : 33);
      run(u, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, u == 1 ? 2 : 33);
      run(u, MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, u == 1 ? 2 : 33);
      run(u, MUL, 32'd12345, 32'd6789, 32'd83810205, u == 1 ? 2 : 33);
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run(i % 2, o, a, b, model(o, a, b), lat_of(i % 2, o, a, b));
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; op[0] = MULHU; rs1[0] = 32'hFFFFFFFF; rs2[0] = 32'hFFFFFFFF;
    exp_q.push_back(32'hFFFFFFFE);
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 1;
    while (!out_valid[0] && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid[0] !== 1'b1 || result[0] !== exp_q[0] || in_ready[0] !== 1'b0) begin
        errors++; $display("FAIL backpressure hold %0d: out_valid=%b result=%h in_ready=%b, expected 1 %h 0", i, out_valid[0], result[0], in_ready[0], exp_q[0]);
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    checks++;
    if (result[0] !== exp_q.pop_front()) begin errors++; $display("FAIL backpressure result: got %h expected fffffffe", result[0]); end
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin errors++; $display("FAIL backpressure release: in_ready=%b out_valid=%b, expected 1 0", in_ready[0], out_valid[0]); end
  endtask

  task automatic abort_mid(input bit use_rst);
    bit seen;
    in_valid[0] = 1'b1; op[0] = DIVU; rs1[0] = 32'd1000; rs2[0] = 32'd3;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (9) @(negedge clk);
    if (use_rst) rst = 1'b1; else flush[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || (use_rst && result[0] !== 32'h0)) begin
      errors++; $display("FAIL abort rst=%0d: in_ready=%b busy=%b out_valid=%b result=%h", use_rst, in_ready[0], busy[0], out_valid[0], result[0]);
    end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= out_valid[0]; end
    checks++;
    if (seen) begin errors++; $display("FAIL abort rst=%0d: out_valid=1 after abort, expected 0", use_rst); end
    run(0, DIVU, 32'd1000, 32'd3, 32'd333, 33);
  endtask

  task automatic test_flush();
    abort_mid(1'b0);
    in_valid[0] = 1'b1; flush[0] = 1'b1; op[0] = DIV; rs1[0] = 32'd9; rs2[0] = 32'd3;
    @(negedge clk);
    in_valid[0] = 1'b0; flush[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin errors++; $display("FAIL flush beats in_valid: busy=%b in_ready=%b, expected 0 1", busy[0], in_ready[0]); end
  endtask

  task automatic test_rst_mid();
    abort_mid(1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; flush = '0; out_ready = 2'b11; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_div();
    test_div_special();
    test_mul();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
